// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: drives an LFSR test pattern into the CUT, compacts the
// responses into a MISR signature, and grades signature and step count on finish.
module bist_response_analyzer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SEED      = 8'h01,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [WIDTH-1:0] MISR_TAPS = 8'hB8,
    parameter logic [WIDTH-1:0] GOLDEN    = 8'h00,
    parameter int               EXP_COUNT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             running,
    input  logic             toggle,
    input  logic             finish,
    input  logic [WIDTH-1:0] cut_out,
    output logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] signature,
    output logic [7:0]       count,
    output logic             done,
    output logic             pass,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        REPORT  = 2'd3
    } state_t;

    localparam logic [7:0] EXP_COUNT_V = EXP_COUNT[7:0];

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [WIDTH-1:0] signature_q, signature_d;
    logic [7:0]       count_q, count_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             proto_err_q, proto_err_d;
    logic             step;

    // Galois shift: shift right, fold the tap mask in when a one falls out.
    function automatic logic [WIDTH-1:0] lstep(input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] taps);
        return (q >> 1) ^ (q[0] ? taps : '0);
    endfunction

    assign step = running & toggle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q   <= SEED;
            signature_q <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            signature_q <= signature_d;
            count_q     <= count_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: if (finish) state_d = CHECK;
                CHECK:   state_d = REPORT;
                default: state_d = state_q;
            endcase
        end
    end

    // init wins in every state; REPORT holds everything until the next init.
    always_comb begin
        pattern_d   = pattern_q;
        signature_d = signature_q;
        count_d     = count_q;
        done_d      = done_q;
        pass_d      = pass_q;
        proto_err_d = proto_err_q;
        if (init) begin
            pattern_d   = SEED;
            signature_d = '0;
            count_d     = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            proto_err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (finish) proto_err_d = 1'b1;
                end
                COLLECT: begin
                    if (step) begin
                        signature_d = lstep(signature_q, MISR_TAPS) ^ cut_out;
                        pattern_d   = lstep(pattern_q, LFSR_TAPS);
                        count_d     = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    end
                end
                CHECK: begin
                    pass_d = (signature_q == GOLDEN) && (count_q == EXP_COUNT_V);
                    done_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign pattern   = pattern_q;
    assign signature = signature_q;
    assign count     = count_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign proto_err = proto_err_q;

endmodule
